// File: rtl/mac_seq_ctrl_pkg.sv
// mac_pkg: shared types and constants for the MAC sequencing controller.
//   state_t     - controller state encoding
//   ACC_W_DEF   - default accumulator width
//   CNT_W_DEF   - default job-length field width
//   OPND_W      - operand width fed to the multiplier
package mac_pkg;

  localparam int ACC_W_DEF = 40;
  localparam int CNT_W_DEF = 8;
  localparam int OPND_W    = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if: job/operand/result signal bundle for mac_seq_ctrl.
//   start, len         - job request and number of operand pairs
//   in_valid, in_ready - operand handshake
//   a, b               - operand pair
//   busy, done         - job status and completion pulse
//   acc_out, ovf       - accumulator and sticky overflow flag
// master: job issuer / operand source.  slave: the controller.
interface mac_seq_ctrl_if
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic              start;
  logic [CNT_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [OPND_W-1:0] a;
  logic [OPND_W-1:0] b;
  logic              busy;
  logic [ACC_W-1:0]  acc_out;
  logic              done;
  logic              ovf;

  modport master (
    output start, len, in_valid, a, b,
    input  in_ready, busy, acc_out, done, ovf
  );

  modport slave (
    input  start, len, in_valid, a, b,
    output in_ready, busy, acc_out, done, ovf
  );

endinterface

// File: rtl/mac_seq_ctrl_vedic.sv
// vedic_32x32: 32x32 multiplier returning the low 32 bits of the product.
//   a, b - operands
//   c    - product modulo 2^32
// Vertical-and-crosswise split on 16-bit halves; the high x high term only
// contributes above bit 31 and is therefore not formed.
module vedic_32x32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] c
);

  logic [31:0] w_ll;
  logic [15:0] w_hl;
  logic [15:0] w_lh;
  logic [15:0] w_mid;

  assign w_ll  = {16'b0, a[15:0]} * {16'b0, b[15:0]};
  // Cross terms land at bit 16, so only their low halves reach c.
  assign w_hl  = a[31:16] * b[15:0];
  assign w_lh  = a[15:0] * b[31:16];
  assign w_mid = w_hl + w_lh;
  assign c     = w_ll + {w_mid, 16'b0};

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences a job of len operand pairs through a registered
// multiply stage into a wrapping accumulator with sticky overflow.
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mac_seq_ctrl_if.slave (job request, operand handshake, result)
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for start; acc_out/ovf hold the last job result
// S_RUN   | accepting operand pairs, in_ready high
// S_DRAIN | last pair captured; its product is added this cycle
// S_DONE  | done pulse with final acc_out, back to S_IDLE
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mac_seq_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [OPND_W-1:0]   r_opa;
  logic [OPND_W-1:0]   r_opb;
  logic                r_stg_vld;
  logic [ACC_W-1:0]    r_acc;
  logic                r_ovf;

  logic                w_in_ready;
  logic                w_busy;
  logic                w_done;
  logic                w_hs;
  logic                w_start_ok;
  logic                w_last;
  logic [OPND_W-1:0]   w_prod;
  logic [ACC_W:0]      w_sum;

  vedic_32x32 u_mult (
    .a (r_opa),
    .b (r_opb),
    .c (w_prod)
  );

  assign w_last     = (r_cnt == CntOne);
  assign w_start_ok = (r_state == S_IDLE) && bus.start;
  assign w_hs       = bus.in_valid && w_in_ready;
  // One extra bit on the sum exposes the carry out of the accumulator.
  assign w_sum      = {1'b0, r_acc} + {{(ACC_W + 1 - OPND_W){1'b0}}, w_prod};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_state_nxt = (bus.len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_stg_vld <= 1'b0;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      // Start is only accepted in IDLE, where no product is pending and no
      // handshake can occur, so these branches never collide.
      if (w_start_ok) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
        r_cnt <= bus.len;
      end else if (r_stg_vld) begin
        r_acc <= w_sum[ACC_W-1:0];
        if (w_sum[ACC_W]) r_ovf <= 1'b1;
      end
      if (w_hs) begin
        r_opa <= bus.a;
        r_opb <= bus.b;
        r_cnt <= r_cnt - CntOne;
      end
      r_stg_vld <= w_hs;
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.acc_out  = r_acc;
  assign bus.ovf      = r_ovf;

endmodule
